// File: rtl/cas_pkg.sv
// Shared cassette definitions: recorder FSM states and the
// nominal FSK period thresholds used by both record and playback.
package cas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } rec_state_t;

    localparam int         CAS_MIN_P  = 150;
    localparam int         CAS_THRESH = 560;
    localparam int         CAS_MAX_P  = 1100;
    localparam logic [7:0] CAS_SYNC   = 8'h55;

endpackage

// File: rtl/cassette_recorder_meter.sv
// FSK period meter: synchronises cas_in, finds rising edges and
// classifies the ce-tick period between accepted edges.
module cas_period_meter
    import cas_pkg::*;
#(
    parameter int MIN_P  = CAS_MIN_P,
    parameter int THRESH = CAS_THRESH,
    parameter int MAX_P  = CAS_MAX_P
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic cas_in,
    output logic bit_valid,
    output logic bit_val,
    output logic gap,
    output logic timeout
);

    localparam int CW = $clog2(MAX_P + 2);
    localparam logic [CW-1:0] SAT = CW'(MAX_P + 1);
    localparam logic [CW-1:0] MINV = CW'(MIN_P);
    localparam logic [CW-1:0] THR = CW'(THRESH);
    localparam logic [CW-1:0] MAXV = CW'(MAX_P);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise, accept;

    assign rise    = sync_q[1] & ~prev_q;
    assign accept  = rise && (cnt_q >= MINV);
    assign bit_valid = accept && (cnt_q <= MAXV);
    assign bit_val = cnt_q < THR;
    assign gap     = accept && (cnt_q > MAXV);
    assign timeout = cnt_q == SAT;

    // Glitch edges leave the count running; accepted edges restart it.
    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if (ce && cnt_q != SAT)
            cnt_d = cnt_q + 1'b1;
    end

    // Two-flop synchroniser, edge history and period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], cas_in};
            prev_q <= sync_q[1];
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cassette_recorder.sv
// Cassette record path: FSK bits to leader-aligned bytes, written
// into tape memory through a request/ack port with a bounded pointer.
module cassette_recorder
    import cas_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter int         MIN_P     = CAS_MIN_P,
    parameter int         THRESH    = CAS_THRESH,
    parameter int         MAX_P     = CAS_MAX_P,
    parameter logic [7:0] SYNC_BYTE = CAS_SYNC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              record,
    input  logic              clear,
    input  logic              cas_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] length,
    output logic              overrun,
    output logic              locked
);

    localparam logic [ADDR_W-1:0] TOP = '1;

    logic bit_valid, bit_val, gap, timeout, lost;

    cas_period_meter #(
        .MIN_P  (MIN_P),
        .THRESH (THRESH),
        .MAX_P  (MAX_P)
    ) u_meter (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .cas_in    (cas_in),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .gap       (gap),
        .timeout   (timeout)
    );

    assign lost = timeout | gap;

    rec_state_t        state_q, state_d;
    logic [7:0]        win_q, win_d, shifted;
    logic [2:0]        bc_q, bc_d;
    logic              emit;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              ovr_q, ovr_d;
    logic              full_q, full_d;
    logic              clrp_q, clrp_d;

    assign shifted = {bit_val, win_q[7:1]};

    // Framing FSM: hunt for the leader byte, then slice every 8 bits.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        bc_d    = bc_q;
        emit    = 1'b0;
        if (!record) begin
            state_d = IDLE;
            win_d   = '0;
            bc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = HUNT;
                HUNT: begin
                    if (lost) begin
                        win_d = '0;
                        bc_d  = '0;
                    end else if (bit_valid) begin
                        win_d = shifted;
                        if (shifted == SYNC_BYTE) begin
                            emit    = 1'b1;
                            state_d = LOCKED;
                            bc_d    = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lost) begin
                        state_d = HUNT;
                        win_d   = '0;
                        bc_d    = '0;
                    end else if (bit_valid) begin
                        win_d = shifted;
                        bc_d  = bc_q + 1'b1;
                        emit  = bc_q == 3'd7;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write port: the ack is retired first so a same-cycle byte can
    // issue at the advanced pointer; the pointer sticks at the top.
    always_comb begin
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        len_d  = len_q;
        ovr_d  = ovr_q;
        full_d = full_q;
        clrp_d = clrp_q;
        if (mem_ack && wr_q) begin
            wr_d = 1'b0;
            if (clrp_q || clear) begin
                ptr_d  = '0;
                len_d  = '0;
                ovr_d  = 1'b0;
                full_d = 1'b0;
                clrp_d = 1'b0;
            end else if (ptr_q == TOP) begin
                full_d = 1'b1;
                len_d  = TOP;
            end else begin
                ptr_d = ptr_q + 1'b1;
                len_d = ptr_q + 1'b1;
            end
        end else if (clear) begin
            if (wr_q) begin
                clrp_d = 1'b1;
            end else begin
                ptr_d  = '0;
                len_d  = '0;
                ovr_d  = 1'b0;
                full_d = 1'b0;
            end
        end
        if (emit) begin
            if (!wr_d && !full_d) begin
                wr_d   = 1'b1;
                addr_d = ptr_d;
                data_d = shifted;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and write-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            bc_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            ovr_q   <= 1'b0;
            full_q  <= 1'b0;
            clrp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            bc_q    <= bc_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            ovr_q   <= ovr_d;
            full_q  <= full_d;
            clrp_q  <= clrp_d;
        end
    end

    assign mem_wr   = wr_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign length   = len_q;
    assign overrun  = ovr_q;
    assign locked   = state_q == LOCKED;

endmodule
